// File: rtl/rbcp_word_master.sv
// RBCP initiator: one 32-bit word request becomes four big-endian single-byte
// RBCP accesses, with a per-byte ack timeout so every request gets one response.
module rbcp_word_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,
    output logic        rbcp_act,
    output logic [31:0] rbcp_addr,
    output logic [7:0]  rbcp_wd,
    output logic        rbcp_we,
    output logic        rbcp_re,
    input  logic        rbcp_ack,
    input  logic [7:0]  rbcp_rd
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    // Last WAIT count value before the byte is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        write_reg, write_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [1:0]  k_reg, k_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        error_reg, error_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [7:0]  wd_reg, wd_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;

    logic [7:0]  wbyte [4];
    logic [31:0] rdata_cap;
    logic        capture;

    assign capture = (state_reg == WAIT) && rbcp_ack && !write_reg;

    // Byte k sits at bits [31-8k -: 8]; rdata_cap merges the acked byte in place.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign wbyte[gi] = wdata_reg[8*(3-gi) +: 8];
            assign rdata_cap[8*(3-gi) +: 8] = (capture && (k_reg == 2'(gi))) ?
                                              rbcp_rd : rdata_reg[8*(3-gi) +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            wdata_reg     <= 32'h0;
            k_reg         <= 2'd0;
            rdata_reg     <= 32'h0;
            error_reg     <= 1'b0;
            cnt_reg       <= 16'h0;
            addr_reg      <= 32'h0;
            wd_reg        <= 8'h0;
            rsp_rdata_reg <= 32'h0;
        end else begin
            state_reg     <= state_next;
            write_reg     <= write_next;
            wdata_reg     <= wdata_next;
            k_reg         <= k_next;
            rdata_reg     <= rdata_next;
            error_reg     <= error_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wd_reg        <= wd_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        write_next     = write_reg;
        wdata_next     = wdata_reg;
        k_next         = k_reg;
        rdata_next     = rdata_reg;
        error_next     = error_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        wd_next        = wd_reg;
        rsp_rdata_next = rsp_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    write_next = req_write;
                    wdata_next = req_wdata;
                    k_next     = 2'd0;
                    rdata_next = 32'h0;
                    error_next = 1'b0;
                    addr_next  = req_addr;
                    wd_next    = req_write ? req_wdata[31:24] : 8'h00;
                    state_next = STROBE;
                end
            end
            STROBE: begin
                cnt_next   = 16'h0;
                state_next = WAIT;
            end
            WAIT: begin
                if (rbcp_ack) begin
                    rdata_next = rdata_cap;
                    if (k_reg == 2'd3) begin
                        rsp_rdata_next = write_reg ? 32'h0 : rdata_cap;
                        state_next     = DONE;
                    end else begin
                        k_next     = k_reg + 2'd1;
                        addr_next  = addr_reg + 32'd1;
                        wd_next    = write_reg ? wbyte[k_reg + 2'd1] : 8'h00;
                        state_next = STROBE;
                    end
                end else if (cnt_reg == TO_LAST) begin
                    // Abandon the remaining bytes; already captured bytes are reported.
                    error_next     = 1'b1;
                    rsp_rdata_next = write_reg ? 32'h0 : rdata_reg;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rbcp_act  = (state_reg == STROBE) || (state_reg == WAIT);
    assign rbcp_we   = (state_reg == STROBE) && write_reg;
    assign rbcp_re   = (state_reg == STROBE) && !write_reg;
    assign rbcp_addr = addr_reg;
    assign rbcp_wd   = wd_reg;
    assign rsp_valid = (state_reg == DONE);
    assign rsp_error = (state_reg == DONE) && error_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_rbcp_word_master.sv
// Directed bench for rbcp_word_master: behavioural RBCP responder with
// programmable ack latency/limit, negedge monitor and a single check task.
module tb_rbcp_word_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        rbcp_act, rbcp_we, rbcp_re, rbcp_ack;
    logic [31:0] rbcp_addr;
    logic [7:0]  rbcp_wd, rbcp_rd;

    always #5 clk = ~clk;

    rbcp_word_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr), .rbcp_wd(rbcp_wd),
        .rbcp_we(rbcp_we), .rbcp_re(rbcp_re), .rbcp_ack(rbcp_ack), .rbcp_rd(rbcp_rd)
    );

    // Responder: acks resp_lat cycles after the strobe cycle, up to ack_limit acks in total.
    logic        resp_ack = 1'b0, spur_ack = 1'b0;
    logic [7:0]  resp_rd = 8'h00;
    logic [7:0]  rd_table [4];
    int          resp_lat = 1;
    int          ack_limit = 32'h7fffffff;
    int          acks_given = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    assign rbcp_ack = resp_ack | spur_ack;
    assign rbcp_rd  = resp_rd;

    always @(posedge clk) begin
        resp_ack <= 1'b0;
        if (rbcp_we || rbcp_re) begin
            if (acks_given < ack_limit) begin
                acks_given <= acks_given + 1;
                pend_addr  <= rbcp_addr;
                if (resp_lat <= 1) begin
                    resp_ack <= 1'b1;
                    resp_rd  <= rd_table[rbcp_addr[1:0]];
                end else begin
                    pend_cnt <= resp_lat - 1;
                end
            end
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                resp_ack <= 1'b1;
                resp_rd  <= rd_table[pend_addr[1:0]];
            end
        end
    end

    // Monitor, sampling between active edges.
    int          cyc = 0, accept_cnt = 0, accept_cyc = 0, rsp_cnt = 0, rsp_cyc = 0, act_gaps = 0;
    logic        busy = 1'b0, rsp_err_s = 1'b0;
    logic [31:0] rsp_data_s = 32'h0;
    logic [31:0] strb_addr [$];
    logic [7:0]  strb_wd [$];
    logic        strb_we [$];

    always @(negedge clk) begin
        if (!rst) begin
            busy = 1'b0;
        end else begin
            if (rbcp_we || rbcp_re) begin
                strb_addr.push_back(rbcp_addr);
                strb_wd.push_back(rbcp_wd);
                strb_we.push_back(rbcp_we);
            end
            if (busy && !rbcp_act && !rsp_valid) act_gaps++;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc    = cyc;
                rsp_err_s  = rsp_error;
                rsp_data_s = rsp_rdata;
                busy       = 1'b0;
                $display("txn rsp #%0d err=%0d rdata=%08h latency=%0d", rsp_cnt, rsp_error, rsp_rdata, cyc - accept_cyc);
            end
            if (req_valid && req_ready) begin
                accept_cnt++;
                accept_cyc = cyc;
                busy       = 1'b1;
            end
        end
        cyc++;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_table(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        rd_table[0] = b0; rd_table[1] = b1; rd_table[2] = b2; rd_table[3] = b3;
    endtask

    task automatic clear_strobes();
        strb_addr.delete(); strb_wd.delete(); strb_we.delete();
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 400 && rsp_cnt < n; i++) tick();
        check("rsp_seen", 64'(rsp_cnt), 64'(n));
    endtask

    task automatic do_word(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = accept_cnt + 1;
        req_write = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        for (int i = 0; i < 50 && accept_cnt < n; i++) tick();
        req_valid = 1'b0;
        check("accepted", 64'(accept_cnt), 64'(n));
        wait_rsp(rsp_cnt + 1);
    endtask

    // Expected address of strobe i is a0+i (mod 2^32); write data is byte i of dexp, MSB first.
    task automatic check_strobes(input string tag, input int n, input logic [31:0] a0,
                                 input logic [31:0] dexp, input logic we);
        logic [31:0] exp_a;
        logic [7:0]  exp_d;
        check({tag, "_count"}, 64'(strb_addr.size()), 64'(n));
        for (int i = 0; i < n && i < strb_addr.size(); i++) begin
            exp_a = a0 + 32'(i);
            exp_d = we ? 8'(dexp >> (8 * (3 - i))) : 8'h00;
            check($sformatf("%s_addr%0d", tag, i), 64'(strb_addr[i]), 64'(exp_a));
            check($sformatf("%s_wd%0d", tag, i), 64'(strb_wd[i]), 64'(exp_d));
            check($sformatf("%s_we%0d", tag, i), 64'(strb_we[i]), 64'(we));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_rsp;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        set_table(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_outs", 64'({rsp_valid, rsp_error, rbcp_act, rbcp_we, rbcp_re}), 64'd0);
        check("rst_addr", 64'(rbcp_addr), 64'd0);
        check("rst_wd", 64'(rbcp_wd), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Write 11223344 to 0, ack latency 1
        clear_strobes(); act_gaps = 0; resp_lat = 1;
        do_word(1'b1, 32'h0, 32'h11223344);
        check_strobes("wr0", 4, 32'h0, 32'h11223344, 1'b1);
        check("wr0_act_gaps", 64'(act_gaps), 64'd0);
        check("wr0_latency", 64'(rsp_cyc - accept_cyc), 64'd9);
        check("wr0_err", 64'(rsp_err_s), 64'd0);
        check("wr0_rdata", 64'(rsp_data_s), 64'd0);

        // Read addr 8, ack latency 3
        clear_strobes(); act_gaps = 0; resp_lat = 3;
        do_word(1'b0, 32'h8, 32'h0);
        check_strobes("rd8", 4, 32'h8, 32'h0, 1'b0);
        check("rd8_act_gaps", 64'(act_gaps), 64'd0);
        check("rd8_latency", 64'(rsp_cyc - accept_cyc), 64'd17);
        check("rd8_err", 64'(rsp_err_s), 64'd0);
        check("rd8_rdata", 64'(rsp_data_s), 64'h11223344);

        // Read across the 32-bit address wrap; table maps addr[1:0] 2,3,0,1
        clear_strobes(); resp_lat = 1;
        do_word(1'b0, 32'hFFFFFFFE, 32'h0);
        check_strobes("wrap", 4, 32'hFFFFFFFE, 32'h0, 1'b0);
        check("wrap_rdata", 64'(rsp_data_s), 64'h33441122);

        // Timeout on byte 2: 8 unanswered WAIT cycles, byte 3 never strobed
        clear_strobes(); resp_lat = 1; set_table(8'h55, 8'h66, 8'h77, 8'h88);
        ack_limit = acks_given + 2;
        do_word(1'b0, 32'h8, 32'h0);
        check_strobes("tmo", 3, 32'h8, 32'h0, 1'b0);
        check("tmo_err", 64'(rsp_err_s), 64'd1);
        check("tmo_rdata", 64'(rsp_data_s), 64'h55660000);
        check("tmo_latency", 64'(rsp_cyc - accept_cyc), 64'd14);
        ack_limit = 32'h7fffffff;

        // Reset during WAIT of byte 2 of a write
        clear_strobes(); resp_lat = 3; base_rsp = rsp_cnt;
        req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 50 && strb_addr.size() < 3; i++) tick();
        check("rstw_strobes", 64'(strb_addr.size()), 64'd3);
        rst = 1'b0;
        tick();
        check("rstw_act", 64'(rbcp_act), 64'd0);
        check("rstw_ready", 64'(req_ready), 64'd1);
        rst = 1'b1;
        repeat (12) tick();
        check("rstw_no_rsp", 64'(rsp_cnt), 64'(base_rsp));
        clear_strobes(); resp_lat = 1;
        do_word(1'b1, 32'h0, 32'h55667788);
        check_strobes("after_rst", 4, 32'h0, 32'h55667788, 1'b1);
        check("after_rst_err", 64'(rsp_err_s), 64'd0);
        check("after_rst_latency", 64'(rsp_cyc - accept_cyc), 64'd9);

        // Spurious acks in IDLE, then a request held while busy
        base_acc = accept_cnt; base_rsp = rsp_cnt;
        for (int i = 0; i < 3; i++) begin
            spur_ack = 1'b1;
            tick();
            spur_ack = 1'b0;
            check($sformatf("spur_ready%0d", i), 64'(req_ready), 64'd1);
            check($sformatf("spur_act%0d", i), 64'(rbcp_act), 64'd0);
            tick();
        end
        check("spur_no_rsp", 64'(rsp_cnt), 64'(base_rsp));
        req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
        for (int i = 0; i < 50 && accept_cnt < base_acc + 1; i++) tick();
        req_addr = 32'h100; req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 100 && accept_cnt < base_acc + 2; i++) tick();
        check("queue_second_accept", 64'(accept_cnt), 64'(base_acc + 2));
        check("queue_first_rsp", 64'(rsp_cnt), 64'(base_rsp + 1));
        check("queue_accept_gap", 64'(accept_cyc - rsp_cyc), 64'd1);
        clear_strobes();
        req_valid = 1'b0;
        wait_rsp(base_rsp + 2);
        check_strobes("queue_b", 4, 32'h100, 32'hCAFEF00D, 1'b1);
        repeat (5) tick();
        check("queue_once", 64'(accept_cnt), 64'(base_acc + 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rbcp_word_master.md
Name: rbcp_word_master

Overview:
- Synthesizable RBCP initiator that turns one 32-bit word request into four sequential single-byte RBCP accesses.
- Used in-fabric, for self-test and local control, to drive the RBCP-to-GPIO adapter and any other RBCP responder in place of SiTCP.
- Byte order is big-endian: address A carries bits [31:24] and A+3 carries bits [7:0].
- A per-byte ack timeout guarantees that every accepted request produces exactly one response.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles per byte before abort; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-low reset
- req_valid  in  1  word request valid
- req_ready  out  1  master idle, request accepted when valid&ready
- req_write  in  1  1 = write word, 0 = read word
- req_addr  in  32  byte address of MSB byte
- req_wdata  in  32  write word
- rsp_valid  out  1  one-cycle response pulse
- rsp_error  out  1  valid with rsp_valid; 1 = ack timeout
- rsp_rdata  out  32  read word, valid with rsp_valid
- rbcp_act  out  1  RBCP transaction active
- rbcp_addr  out  32  RBCP byte address
- rbcp_wd  out  8  RBCP write data
- rbcp_we  out  1  RBCP write strobe (1-cycle)
- rbcp_re  out  1  RBCP read strobe (1-cycle)
- rbcp_ack  in  1  responder ack (1-cycle pulse)
- rbcp_rd  in  8  responder read data, valid with rbcp_ack

Behaviour:
- Reset is rst==0 sampled at a clk edge.
  - Outputs after reset: req_ready=1; rsp_valid, rsp_error, rbcp_act, rbcp_we, rbcp_re = 0; rbcp_addr, rbcp_wd, rsp_rdata = 0.
  - Internal state returns to IDLE.
  - Reset mid-transaction aborts immediately with no rsp_valid; rbcp_act drops on the same edge.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - req_ready=1 and rbcp_act=0.
  - On req_valid: latch write, addr and wdata; clear byte index k=0, rdata and error; go to STROBE.
- STROBE (exactly one cycle):
  - rbcp_act=1; rbcp_addr = addr+k, mod 2^32 (wraps from FFFFFFFF to 0).
  - Write: rbcp_we=1 and rbcp_wd = wdata[31-8k -: 8].
  - Read: rbcp_re=1 and rbcp_wd=0.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - rbcp_act=1; rbcp_addr and rbcp_wd held; strobes are 0.
  - On rbcp_ack for a read: capture rbcp_rd into rdata[31-8k -: 8].
  - On rbcp_ack: if k==3 go to DONE, else k++ and go to STROBE.
  - If no ack and the counter reaches TIMEOUT_CYCLES: error=1; go to DONE; remaining bytes are skipped.
- DONE (one cycle):
  - rsp_valid=1, rsp_error=error, rbcp_act=0; go to IDLE.
  - rsp_rdata = captured rdata for reads; bytes not received stay 0. For writes rsp_rdata = 0.
  - rsp_rdata holds its value until the next DONE.
- rbcp_act stays high continuously across all four bytes of one word and goes low in DONE and IDLE.
- rbcp_ack sampled outside WAIT (IDLE, STROBE, DONE) is ignored.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Latency: with the responder acking L≥1 cycles after the strobe cycle, rsp_valid occurs 4·(L+1)+1 cycles after the accept edge. For L=1 this is 9 cycles.
- Back-to-back: req_ready returns 1 the cycle after DONE, so a new accept is possible one cycle after rsp_valid.
- Timeout counter width: 16 bits.

Test Plan:
- Write 32'h11223344 to addr 0, responder acks after 1 cycle:
  - 4 we pulses with addr/wd 0/11, 1/22, 2/33, 3/44.
  - rbcp_act continuous high.
  - rsp_valid 9 cycles after accept, rsp_error=0.
- Read addr 8, responder returns 11,22,33,44 for addr 8..11 with ack latency 3:
  - rsp_rdata=32'h11223344, rsp_error=0.
  - rsp_valid 17 cycles after accept.
- Read addr 32'hFFFFFFFE: rbcp_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.
- TIMEOUT_CYCLES=8, read addr 8, responder acks bytes 0 and 1 (55, 66) then never acks:
  - No strobe for byte 3.
  - rsp_valid with rsp_error=1, rsp_rdata=32'h55660000.
- Reset during WAIT of byte 2 of a write:
  - rbcp_act=0 and req_ready=1 after the reset edge; no rsp_valid.
  - Next write 32'h55667788 to addr 0 completes normally.
- Spurious rbcp_ack pulses in IDLE, plus req_valid held during busy:
  - No state change; a second request queued behind the first is accepted exactly once, one cycle after the first rsp_valid.
